instr_fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the B32P pipeline: issues word reads on the instruction bus,

---
 rtl/instr_fetch_ctrl.sv | 124 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding word read, PC-tagged FIFO, decoder handshake.
// Optional INSTR_FETCH_PREDECODE_EN follows absolute JUMP words when advancing fetch_pc.
module instr_fetch_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        bus_start,
  output logic [31:0] bus_addr,
  input  logic        bus_done,
  input  logic [31:0] bus_q,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   mem_w  [DEPTH];
  logic [31:0]   mem_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   fetch_pc, fetch_pc_nx, seq_pc;
  logic          issue, push, pop;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if ((count < FULL) && !redirect) begin
          issue    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus_done) begin
          push     = !redirect;
          state_nx = IDLE;
        end else if (redirect) begin
          state_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (bus_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop = (count != '0) && instr_ready;

`ifdef INSTR_FETCH_PREDECODE_EN
  // Absolute JUMP (opcode 1001, bit0 clear) redirects sequential fetch to its target early.
  always_comb begin
    seq_pc = fetch_pc + 32'd1;
    if ((bus_q[31:28] == 4'b1001) && !bus_q[0]) seq_pc = {5'd0, bus_q[27:1]};
  end
`else
  assign seq_pc = fetch_pc + 32'd1;
`endif

  always_comb begin
    fetch_pc_nx = fetch_pc;
    if (redirect)  fetch_pc_nx = redirect_addr;
    else if (push) fetch_pc_nx = seq_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_start <= 1'b0;
      bus_addr  <= '0;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      bus_start <= issue;
      if (issue) bus_addr <= fetch_pc;
      fetch_pc  <= fetch_pc_nx;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: reads are masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_w[wr_ptr]  <= bus_q;
      mem_pc[wr_ptr] <= bus_addr;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_w[rd_ptr]  : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: queue-based fetch model plus directed scenarios.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int          LAT      = 2;
`ifdef INSTR_FETCH_PREDECODE_EN
  localparam bit PREDECODE = 1'b1;
`else
  localparam bit PREDECODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        bus_start;
  logic [31:0] bus_addr;
  logic        bus_done = 1'b0;
  logic [31:0] bus_q = '0;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  instr_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .bus_start(bus_start), .bus_addr(bus_addr), .bus_done(bus_done), .bus_q(bus_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  ent_t        accepted[$];
  logic [31:0] issued[$];
  logic [31:0] mpc = RESET_PC;
  logic [31:0] m_req = '0;
  logic        m_out = 1'b0, m_disc = 1'b0, armed = 1'b0, elig = 1'b0;
  logic        cur_valid = 1'b0;
  logic [31:0] cur_instr = '0, cur_pc = '0;
  logic        s_r, s_rd, s_d, s_rdy;
  logic [31:0] s_ra, s_q;
  bit          jw_en = 1'b0;
  logic        fired = 1'b0;
  int          rsp_wait = 0;
  logic [31:0] rsp_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: entry missing", name);
  endtask

  task automatic chk_iss(input string name, input int i, input logic [31:0] exp);
    if (i < issued.size()) chk(name, issued[i], exp);
    else miss(name);
  endtask

  task automatic chk_acc(input string name, input int i, input logic [31:0] w, input logic [31:0] pc);
    if (i < accepted.size()) begin
      chk({name, "_w"}, accepted[i].w, w);
      chk({name, "_pc"}, accepted[i].pc, pc);
    end else miss(name);
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
    if (PREDECODE && (w[31:28] == 4'b1001) && !w[0]) return {5'd0, w[27:1]};
    return pc + 32'd1;
  endfunction

  function automatic logic [31:0] resp_word(input logic [31:0] a);
    if (jw_en && (a == 32'd3)) return 32'h9000_0100;
    return a + 32'd100;
  endfunction

  // Model: FIFO as a queue of (word, pc); one request in flight; issue whenever idle and not full.
  always begin
    @(posedge clk);
    s_r = reset; s_rd = redirect; s_ra = redirect_addr;
    s_d = bus_done; s_q = bus_q; s_rdy = instr_ready;
    if (s_r) begin
      mq.delete();
      mpc = RESET_PC; m_out = 1'b0; m_disc = 1'b0; elig = 1'b0; armed = 1'b1;
    end else if (armed) begin
      elig = !m_out && (mq.size() < DEPTH) && !s_rd;
      if (cur_valid && s_rdy) accepted.push_back({cur_instr, cur_pc});
      if ((mq.size() > 0) && s_rdy) void'(mq.pop_front());
      if (s_d && m_out) begin
        if (!(m_disc || s_rd)) begin
          ent_t e;
          e.w = s_q;
          e.pc = m_req;
          mq.push_back(e);
          mpc = next_pc(mpc, s_q);
        end
        m_out = 1'b0;
        m_disc = 1'b0;
      end
      if (s_rd) begin
        mq.delete();
        mpc = s_ra;
        if (m_out) m_disc = 1'b1;
      end
    end
    #1;
    if (armed) begin
      chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
      chk("instr", instr, (mq.size() != 0) ? mq[0].w : 32'd0);
      chk("instr_pc", instr_pc, (mq.size() != 0) ? mq[0].pc : 32'd0);
      chk("bus_start", 32'(bus_start), 32'(elig));
      if (s_r) chk("bus_addr_reset", bus_addr, 32'd0);
      if (bus_start && !s_r) begin
        chk("bus_addr", bus_addr, mpc);
        m_out = 1'b1;
        m_req = mpc;
        issued.push_back(bus_addr);
      end
    end
    cur_valid = instr_valid; cur_instr = instr; cur_pc = instr_pc;
  end

  // One cycle of stimulus driven at the falling edge, including the bus responder.
  task automatic cyc(input logic rst, input logic rdy, input logic rd, input logic [31:0] ra,
                     input logic rd_on_done);
    @(negedge clk);
    reset = rst; instr_ready = rdy; redirect = rd; redirect_addr = ra;
    bus_done = 1'b0; fired = 1'b0;
    if (rst) rsp_wait = 0;
    else if (bus_start) begin
      rsp_wait = LAT;
      rsp_addr = bus_addr;
    end else if (rsp_wait > 0) begin
      rsp_wait--;
      if (rsp_wait == 0) begin
        bus_done = 1'b1;
        bus_q = resp_word(rsp_addr);
        if (rd_on_done && (mq.size() > 0)) begin
          redirect = 1'b1; instr_ready = 1'b1; fired = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input int n, input logic rdy);
    repeat (n) cyc(1'b0, rdy, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic clear_logs();
    issued.delete();
    accepted.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential fetch, decoder always ready
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    clear_logs();
    run(20, 1'b1);
    chk_iss("t1_addr0", 0, 32'd0);
    chk_iss("t1_addr1", 1, 32'd1);
    chk_iss("t1_addr2", 2, 32'd2);
    chk_acc("t1_acc0", 0, 32'd100, 32'd0);
    chk_acc("t1_acc1", 1, 32'd101, 32'd1);
    chk_acc("t1_acc2", 2, 32'd102, 32'd2);

    // Stalled decoder fills the FIFO, then a single pop frees one slot
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    clear_logs();
    run(30, 1'b0);
    chk("t2_issues_full", 32'(issued.size()), 32'd4);
    chk("t2_head_valid", 32'(instr_valid), 32'd1);
    chk("t2_head_pc", instr_pc, 32'd0);
    chk("t2_head_w", instr, 32'd100);
    run(1, 1'b1);
    run(12, 1'b0);
    chk("t2_issues_after_pop", 32'(issued.size()), 32'd5);
    chk_iss("t2_addr4", 4, 32'd4);
    chk("t2_pops", 32'(accepted.size()), 32'd1);
    chk_acc("t2_acc0", 0, 32'd100, 32'd0);

    // Redirect while the request to 5 is outstanding
    clear_logs();
    run(1, 1'b1);
    for (int i = 0; i < 10 && issued.size() == 0; i++) run(1, 1'b0);
    chk_iss("t3_addr5", 0, 32'd5);
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    run(1, 1'b0);
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    clear_logs();
    run(15, 1'b1);
    chk_iss("t3_addr40", 0, 32'h40);
    chk_acc("t3_acc0", 0, 32'h40 + 32'd100, 32'h40);

    // Redirect coincident with bus_done and a pop
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    clear_logs();
    for (int i = 0; i < 30 && !fired; i++) cyc(1'b0, 1'b0, 1'b0, 32'h200, 1'b1);
    if (!fired) miss("t4_coincident_done");
    run(1, 1'b0);
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_pop_counted", 32'(accepted.size()), 32'd1);
    chk_acc("t4_acc0", 0, 32'd100, 32'd0);
    clear_logs();
    run(12, 1'b1);
    chk_iss("t4_addr200", 0, 32'h200);
    chk_acc("t4_acc_new", 0, 32'h200 + 32'd100, 32'h200);

    // PC wrap at the top of the address space, then reset mid-run
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    clear_logs();
    run(12, 1'b1);
    chk_iss("t5_addr_top", 0, 32'hFFFF_FFFF);
    chk_iss("t5_addr_wrap", 1, 32'd0);
    chk_acc("t5_acc_top", 0, 32'd99, 32'hFFFF_FFFF);
    chk_acc("t5_acc_wrap", 1, 32'd100, 32'd0);
    run(3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    clear_logs();
    run(1, 1'b0);
    chk("t5_rst_valid", 32'(instr_valid), 32'd0);
    chk("t5_rst_start", 32'(bus_start), 32'd0);
    chk("t5_rst_addr", bus_addr, 32'd0);
    chk("t5_rst_instr", instr, 32'd0);
    chk("t5_rst_pc", instr_pc, 32'd0);
    run(10, 1'b1);
    chk_iss("t5_addr_reset_pc", 0, RESET_PC);

    // JUMP word at pc 3
    cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    jw_en = 1'b1;
    clear_logs();
    run(30, 1'b1);
    chk_iss("t6_addr3", 3, 32'd3);
    chk_iss("t6_after_jump", 4, PREDECODE ? 32'h80 : 32'd4);
    chk_acc("t6_jump_word", 3, 32'h9000_0100, 32'd3);
    jw_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
